// File: rtl/in_demux_if_loader.sv
`default_nettype none
// ============================================================================
// Module   : in_demux_if_loader
// Brief    : Packs IN_W-bit beats into DATA_W-bit rows and writes them into
//            NUM_BANKS banks of WORDS rows each, bank 0 first.
// Revision : 1.0 - initial release
// ============================================================================
module in_demux_if_loader #(
   parameter int IN_W      = 32,
   parameter int DATA_W    = 192,
   parameter int NUM_BANKS = 8,
   parameter int SEL_W     = 3,
   parameter int WORDS     = 9,
   parameter int ADDR_W    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [IN_W-1:0]      in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [SEL_W-1:0]     F,
   output logic [NUM_BANKS-1:0] bank_wr_en,
   output logic [ADDR_W-1:0]    bank_wr_addr,
   output logic [DATA_W-1:0]    bank_wr_data,
   output logic                 busy,
   output logic                 done
);

   localparam int c_beats  = DATA_W / IN_W;
   localparam int c_beat_w = (c_beats > 1) ? $clog2(c_beats) : 1;

   localparam logic [1:0] c_idle     = 2'd0;
   localparam logic [1:0] c_assemble = 2'd1;
   localparam logic [1:0] c_write    = 2'd2;
   localparam logic [1:0] c_done     = 2'd3;

   localparam logic [c_beat_w-1:0]  c_last_beat = c_beat_w'(c_beats - 1);
   localparam logic [ADDR_W-1:0]    c_last_row  = ADDR_W'(WORDS - 1);
   localparam logic [SEL_W-1:0]     c_last_bank = SEL_W'(NUM_BANKS - 1);
   localparam logic [NUM_BANKS-1:0] c_bank0     = NUM_BANKS'(1);

   logic [1:0]           r_state;
   logic [c_beat_w-1:0]  r_beat;
   logic [ADDR_W-1:0]    r_row;
   logic [DATA_W-1:0]    r_row_buf;

   logic [1:0]           w_next;
   logic                 w_accept;
   logic [c_beat_w-1:0]  w_beat;
   logic [ADDR_W-1:0]    w_row;
   logic [DATA_W-1:0]    w_row_buf;
   logic [SEL_W-1:0]     w_f;
   logic                 w_in_ready;
   logic [NUM_BANKS-1:0] w_wr_en;
   logic [ADDR_W-1:0]    w_wr_addr;
   logic [DATA_W-1:0]    w_wr_data;
   logic                 w_busy;
   logic                 w_done;

   assign w_accept = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_idle;
         r_beat       <= '0;
         r_row        <= '0;
         r_row_buf    <= '0;
         F            <= '0;
         in_ready     <= 1'b0;
         bank_wr_en   <= '0;
         bank_wr_addr <= '0;
         bank_wr_data <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_beat       <= w_beat;
         r_row        <= w_row;
         r_row_buf    <= w_row_buf;
         F            <= w_f;
         in_ready     <= w_in_ready;
         bank_wr_en   <= w_wr_en;
         bank_wr_addr <= w_wr_addr;
         bank_wr_data <= w_wr_data;
         busy         <= w_busy;
         done         <= w_done;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_idle:     if (start) w_next = c_assemble;
         c_assemble: if (w_accept && (r_beat == c_last_beat)) w_next = c_write;
         c_write:    w_next = ((r_row == c_last_row) && (F == c_last_bank)) ? c_done : c_assemble;
         c_done:     w_next = c_idle;
         default:    w_next = c_idle;
      endcase
   end

   // Outputs are registered from the next state, so they line up with it.
   always_comb begin
      w_beat    = r_beat;
      w_row     = r_row;
      w_row_buf = r_row_buf;
      w_f       = F;
      w_wr_addr = bank_wr_addr;
      w_wr_data = bank_wr_data;
      case (r_state)
         c_idle: begin
            if (start) begin
               w_beat = '0;
               w_row  = '0;
               w_f    = '0;
            end
         end
         c_assemble: begin
            if (w_accept) begin
               w_row_buf[IN_W*r_beat +: IN_W] = in_data;
               w_beat = (r_beat == c_last_beat) ? '0 : r_beat + 1'b1;
            end
         end
         c_write: begin
            if (r_row != c_last_row) begin
               w_row = r_row + 1'b1;
            end else if (F != c_last_bank) begin
               w_row = '0;
               w_f   = F + 1'b1;
            end
         end
         c_done: begin
            w_row     = '0;
            w_f       = '0;
            w_wr_addr = '0;
         end
         default: ;
      endcase

      if (w_next == c_write) begin
         w_wr_addr = r_row;
         w_wr_data = w_row_buf;
      end
      w_wr_en    = (w_next == c_write) ? (c_bank0 << F) : '0;
      w_in_ready = (w_next == c_assemble);
      w_busy     = (w_next != c_idle);
      w_done     = (w_next == c_done);
   end

endmodule
`default_nettype wire

// File: doc/in_demux_if_loader.md
Name: in_demux_if_loader

Overview:
- Write-side counterpart of the convolution unit's output-select mux.
- Accepts a narrow stream of kernel/feature words and assembles each into a DATA_W-bit row.
- Demultiplexes each row into one of NUM_BANKS storage banks, in bank index order 0..NUM_BANKS-1.
- Fills every bank with WORDS rows so the downstream select mux can read them by index F.

Parameters:
- IN_W, 32, input beat width in bits.
- DATA_W, 192, assembled row width; must be an integer multiple of IN_W (BEATS = DATA_W/IN_W = 6).
- NUM_BANKS, 8, number of destination banks.
- SEL_W, 3, bank index width (log2 NUM_BANKS).
- WORDS, 9, rows written per bank.
- ADDR_W, 4, bank row address width (≥ log2 WORDS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a full load; sampled only in IDLE.
- in_data  input  IN_W  input beat.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a beat.
- F  output  SEL_W  index of the bank currently being filled.
- bank_wr_en  output  NUM_BANKS  one-hot write strobe; bit F asserted.
- bank_wr_addr  output  ADDR_W  row address within the selected bank.
- bank_wr_data  output  DATA_W  assembled row.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse when all NUM_BANKS*WORDS rows are written.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values (all outputs and state registers): state=IDLE, in_ready=0, F=0, bank_wr_en=0, bank_wr_addr=0, bank_wr_data=0, busy=0, done=0, beat counter=0.
- All outputs are registered.
- FSM states: IDLE, ASSEMBLE, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → ASSEMBLE; clear F, row address and beat counter.
- ASSEMBLE:
  - in_ready=1.
  - A beat is accepted on a rising edge with in_valid & in_ready.
  - Beat k (k=0..BEATS-1) is stored in row bits [IN_W*k+IN_W-1 : IN_W*k] (first beat is least significant).
  - The beat counter increments per accepted beat.
  - On acceptance of beat BEATS-1 → WRITE; the counter returns to 0.
  - in_valid low → hold; no state change.
- WRITE (exactly one cycle):
  - in_ready=0.
  - bank_wr_en has only bit F set; bank_wr_addr = current row; bank_wr_data = assembled row.
  - Latency: last beat accepted at edge N → write strobe high during cycle N+1.
  - Exactly one bubble per row on the input side.
- Leaving WRITE:
  - If row < WORDS-1: row+1 → ASSEMBLE.
  - If row = WORDS-1 and F < NUM_BANKS-1: row=0, F+1 → ASSEMBLE.
  - If row = WORDS-1 and F = NUM_BANKS-1 → DONE.
- DONE:
  - done=1 for one cycle; in_ready=0 → IDLE.
  - F and bank_wr_addr return to 0 on entry to IDLE.
- bank_wr_en is 0 in every state except WRITE; it is never multi-hot.
- bank_wr_data and bank_wr_addr hold their last written values outside WRITE; consumers qualify them with bank_wr_en.
- start asserted while busy=1 is ignored, including during the DONE cycle.
- start and the in_valid beat in the same cycle while in IDLE: the beat is not accepted (in_ready=0); the first acceptable beat is the cycle after.
- F never wraps during a load. It reaches NUM_BANKS-1 and then returns to 0 only via DONE→IDLE.
- rst_n asserted mid-operation:
  - Immediate return to IDLE with reset values; the partial row is discarded.
  - No write strobe is issued.
  - After release, a new start is required, and the load restarts from bank 0, row 0.
- Total per load: NUM_BANKS*WORDS = 72 write strobes and 72*BEATS = 432 accepted beats. Minimum load time is 72*(BEATS+1)+2 = 506 cycles from start to done, with in_valid held high.

Test Plan:
- Reset sanity: rst_n=0 then released, no start → all outputs 0 for 20 cycles; in_ready=0, bank_wr_en=8'h00.
- Single-row check:
  - Stimulus: start, then beats 32'h00000001..32'h00000006 with in_valid held high.
  - Required: bank_wr_en=8'h01, bank_wr_addr=0, bank_wr_data=192'h000000060000000500000004000000030000000200000001, asserted one cycle after the 6th beat; in_ready=0 that cycle.
- Full load, continuous valid:
  - Stimulus: 432 incrementing beats.
  - Required: 72 strobes in order bank0 rows 0..8 through bank7 rows 0..8; one-hot bit equals F throughout; done pulses once, 506 cycles after start; busy falls with done.
- Backpressure/gaps:
  - Stimulus: in_valid toggled 1,0,0,1,... (random gaps).
  - Required: identical bank contents to the full-load test; no strobes while beats are missing; F increments only after row 8.
- Ignored start: pulse start during ASSEMBLE of bank 3, row 4 → no counter reset; the load completes normally with 72 strobes.
- Reset mid-load:
  - Stimulus: assert rst_n after 3 beats of bank 5, row 2.
  - Required: outputs return to reset values immediately (asynchronously); no strobe from the partial row. A subsequent start writes from bank0 row0.
